// File: rtl/gpu_sched_pkg.sv
// Shared types and parameter defaults for the kernel launch scheduler.
// The state enum is shared so a future status/debug port can reuse the same encoding.
package gpu_sched_pkg;

    localparam int DEFAULT_QUEUE_DEPTH = 4;
    localparam int DEFAULT_ID_BITS     = 4;
    localparam int THREAD_COUNT_BITS   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_RUN    = 2'd2,
        ST_RETIRE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/launch_fifo.sv
// Synchronous show-ahead FIFO for pending kernel launches.
// Full, empty and count are registered so downstream ready never depends on this cycle's pop.
module launch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_next;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    end

    // Storage carries no reset; only the pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/kernel_scheduler.sv
// Kernel scheduler: queues launch requests and sequences each kernel through
// a fresh dispatch reset, a run phase and a one-cycle retire pulse.
module kernel_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
    parameter int ID_BITS     = DEFAULT_ID_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         launch_valid,
    output logic                         launch_ready,
    input  logic [7:0]                   launch_thread_count,
    input  logic [ID_BITS-1:0]           launch_kernel_id,
    input  logic                         abort,
    output logic                         dispatch_reset,
    output logic                         dispatch_start,
    output logic [7:0]                   dispatch_thread_count,
    input  logic                         dispatch_done,
    output logic                         complete_valid,
    output logic [ID_BITS-1:0]           complete_kernel_id,
    output logic                         complete_aborted,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         busy,
    output logic [7:0]                   kernels_completed
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int EW = THREAD_COUNT_BITS + ID_BITS;

    sched_state_t     r_state;
    logic             r_dispatch_reset;
    logic             r_dispatch_start;
    logic [7:0]       r_thread_count;
    logic [ID_BITS-1:0] r_kernel_id;
    logic             r_complete_valid;
    logic             r_aborted;
    logic [7:0]       r_kernels_completed;

    logic [EW-1:0]    w_fifo_din;
    logic [EW-1:0]    w_head;
    logic [7:0]       w_head_tc;
    logic [ID_BITS-1:0] w_head_id;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_push;
    logic             w_pop;

    assign w_fifo_din = {launch_thread_count, launch_kernel_id};
    assign w_head_tc  = w_head[EW-1:ID_BITS];
    assign w_head_id  = w_head[ID_BITS-1:0];
    assign w_push     = launch_valid && !w_full;
    assign w_pop      = (r_state == ST_IDLE) && !w_empty;

    launch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (EW)
    ) u_launch_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= ST_IDLE;
            r_dispatch_reset    <= 1'b1;
            r_dispatch_start    <= 1'b0;
            r_thread_count      <= '0;
            r_kernel_id         <= '0;
            r_complete_valid    <= 1'b0;
            r_aborted           <= 1'b0;
            r_kernels_completed <= '0;
        end else begin
            r_complete_valid <= 1'b0;
            r_dispatch_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_thread_count <= w_head_tc;
                        r_kernel_id    <= w_head_id;
                        // An empty kernel never touches the dispatch unit.
                        if (w_head_tc == 8'd0) begin
                            r_aborted        <= 1'b1;
                            r_complete_valid <= 1'b1;
                            r_state          <= ST_RETIRE;
                        end else begin
                            r_dispatch_reset <= 1'b1;
                            r_state          <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_dispatch_start <= 1'b1;
                    r_state          <= ST_RUN;
                end
                ST_RUN: begin
                    // Completion takes priority over a coincident abort.
                    if (dispatch_done) begin
                        r_dispatch_start <= 1'b0;
                        r_aborted        <= 1'b0;
                        r_complete_valid <= 1'b1;
                        r_state          <= ST_RETIRE;
                    end else if (abort) begin
                        r_dispatch_start <= 1'b0;
                        r_dispatch_reset <= 1'b1;
                        r_aborted        <= 1'b1;
                        r_complete_valid <= 1'b1;
                        r_state          <= ST_RETIRE;
                    end
                end
                ST_RETIRE: begin
                    if (!r_aborted) begin
                        r_kernels_completed <= r_kernels_completed + 8'd1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign launch_ready          = !w_full;
    assign queue_count           = w_count;
    assign busy                  = (r_state != ST_IDLE) || (w_count != '0);
    assign dispatch_reset        = r_dispatch_reset;
    assign dispatch_start        = r_dispatch_start;
    assign dispatch_thread_count = r_thread_count;
    assign complete_valid        = r_complete_valid;
    assign complete_kernel_id    = r_kernel_id;
    assign complete_aborted      = r_aborted;
    assign kernels_completed     = r_kernels_completed;

endmodule

// File: tb/tb_kernel_scheduler.sv
// Self-checking bench for kernel_scheduler: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model built on a launch queue.
module tb_kernel_scheduler;

    localparam int QD  = 4;
    localparam int IDB = 4;
    localparam int CW  = $clog2(QD) + 1;

    // Model progress of the current kernel, named after the scheduler phases.
    localparam int K_NONE    = 0;
    localparam int K_CLEAR   = 1;
    localparam int K_RUN     = 2;
    localparam int K_RETIRE  = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           launch_valid;
    logic           launch_ready;
    logic [7:0]     launch_thread_count;
    logic [IDB-1:0] launch_kernel_id;
    logic           abort;
    logic           dispatch_reset;
    logic           dispatch_start;
    logic [7:0]     dispatch_thread_count;
    logic           dispatch_done;
    logic           complete_valid;
    logic [IDB-1:0] complete_kernel_id;
    logic           complete_aborted;
    logic [CW-1:0]  queue_count;
    logic           busy;
    logic [7:0]     kernels_completed;

    always #5 clk = ~clk;

    kernel_scheduler #(
        .QUEUE_DEPTH (QD),
        .ID_BITS     (IDB)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .launch_valid          (launch_valid),
        .launch_ready          (launch_ready),
        .launch_thread_count   (launch_thread_count),
        .launch_kernel_id      (launch_kernel_id),
        .abort                 (abort),
        .dispatch_reset        (dispatch_reset),
        .dispatch_start        (dispatch_start),
        .dispatch_thread_count (dispatch_thread_count),
        .dispatch_done         (dispatch_done),
        .complete_valid        (complete_valid),
        .complete_kernel_id    (complete_kernel_id),
        .complete_aborted      (complete_aborted),
        .queue_count           (queue_count),
        .busy                  (busy),
        .kernels_completed     (kernels_completed)
    );

    typedef struct {
        int tc;
        int id;
    } kern_t;

    kern_t q[$];
    int    m_phase;
    bit    m_ready;
    bit    m_dreset;
    bit    m_dstart;
    bit    m_cv;
    bit    m_aborted;
    bit    m_accepted;
    int    m_dtc;
    int    m_id;
    int    m_kc;
    int    m_run_age;
    int    done_delay;
    int    n_cmp;
    int    n_bad;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after one clock edge, given the inputs seen on that edge.
    task automatic model_step(input bit rst, input bit lv, input int ltc, input int lid,
                              input bit ab, input bit dd);
        kern_t k;
        if (rst) begin
            q.delete();
            m_phase    = K_NONE;
            m_dreset   = 1'b1;
            m_dstart   = 1'b0;
            m_dtc      = 0;
            m_id       = 0;
            m_cv       = 1'b0;
            m_aborted  = 1'b0;
            m_kc       = 0;
            m_ready    = 1'b1;
            m_accepted = 1'b0;
            return;
        end
        m_accepted = lv && m_ready;
        m_cv       = 1'b0;
        m_dreset   = 1'b0;
        case (m_phase)
            K_NONE: begin
                if (q.size() > 0) begin
                    k     = q.pop_front();
                    m_dtc = k.tc;
                    m_id  = k.id;
                    if (k.tc == 0) begin
                        m_aborted = 1'b1;
                        m_cv      = 1'b1;
                        m_phase   = K_RETIRE;
                    end else begin
                        m_dreset = 1'b1;
                        m_phase  = K_CLEAR;
                    end
                end
            end
            K_CLEAR: begin
                m_dstart  = 1'b1;
                m_run_age = 0;
                m_phase   = K_RUN;
            end
            K_RUN: begin
                if (dd) begin
                    m_dstart  = 1'b0;
                    m_aborted = 1'b0;
                    m_cv      = 1'b1;
                    m_phase   = K_RETIRE;
                end else if (ab) begin
                    m_dstart  = 1'b0;
                    m_dreset  = 1'b1;
                    m_aborted = 1'b1;
                    m_cv      = 1'b1;
                    m_phase   = K_RETIRE;
                end else begin
                    m_run_age++;
                end
            end
            default: begin
                if (!m_aborted) m_kc = (m_kc + 1) % 256;
                m_phase = K_NONE;
            end
        endcase
        if (m_accepted) q.push_back('{tc: ltc, id: lid});
        m_ready = (q.size() < QD);
    endtask

    task automatic compare_all();
        check_val("queue_count", 32'(queue_count), 32'(q.size()));
        check_val("launch_ready", 32'(launch_ready), 32'(m_ready));
        check_val("busy", 32'(busy), 32'(m_phase != K_NONE || q.size() != 0));
        check_val("dispatch_reset", 32'(dispatch_reset), 32'(m_dreset));
        check_val("dispatch_start", 32'(dispatch_start), 32'(m_dstart));
        check_val("dispatch_thread_count", 32'(dispatch_thread_count), 32'(m_dtc));
        check_val("complete_valid", 32'(complete_valid), 32'(m_cv));
        if (m_cv) begin
            check_val("complete_kernel_id", 32'(complete_kernel_id), 32'(m_id));
            check_val("complete_aborted", 32'(complete_aborted), 32'(m_aborted));
        end
        check_val("kernels_completed", 32'(kernels_completed), 32'(m_kc));
        if (complete_valid) begin
            $display("retire id=%0d aborted=%0d completed=%0d t=%0t",
                     complete_kernel_id, complete_aborted, kernels_completed, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, update the model, sample on the falling edge.
    // The bench acts as the dispatch unit: done rises done_delay cycles into RUN.
    task automatic cycle(input bit rst, input bit lv, input int ltc, input int lid,
                         input bit ab, input bit dd_extra);
        bit dd;
        dd = dd_extra || (m_phase == K_RUN && m_run_age >= done_delay);
        reset               = rst;
        launch_valid        = lv;
        launch_thread_count = 8'(ltc);
        launch_kernel_id    = IDB'(lid);
        abort               = ab;
        dispatch_done       = dd;
        @(posedge clk);
        model_step(rst, lv, ltc, lid, ab, dd);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic launch(input int tc, input int id);
        int n;
        n = 0;
        do begin
            cycle(1'b0, 1'b1, tc, id, 1'b0, 1'b0);
            n++;
        end while (!m_accepted && n < 300);
        check_val("launch_accepted", 32'(m_accepted), 32'd1);
    endtask

    task automatic wait_run_age(input int age);
        int n;
        bit reached;
        n = 0;
        while (!(m_phase == K_RUN && m_run_age == age) && n < 300) begin
            idle(1);
            n++;
        end
        reached = (m_phase == K_RUN && m_run_age == age);
        check_val("wait_run_reached", 32'(reached), 32'd1);
    endtask

    task automatic drain();
        int n;
        bit done;
        n = 0;
        while (!(m_phase == K_NONE && q.size() == 0) && n < 3000) begin
            idle(1);
            n++;
        end
        done = (m_phase == K_NONE && q.size() == 0);
        check_val("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bit rs, lv, ab, dx;
        int tc, id, kc_before;
        n_cmp      = 0;
        n_bad      = 0;
        done_delay = 5;
        m_run_age  = 0;

        // Reset values, then dispatch_reset falls on the first edge after release.
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check_val("rst_dispatch_reset", 32'(dispatch_reset), 32'd1);
        check_val("rst_kernel_id", 32'(complete_kernel_id), 32'd0);
        check_val("rst_aborted", 32'(complete_aborted), 32'd0);
        idle(1);

        // Single launch: reset pulse one edge after accept, start one edge later.
        done_delay = 5;
        launch(10, 3);
        idle(1);
        check_val("single_dispatch_reset", 32'(dispatch_reset), 32'd1);
        idle(1);
        check_val("single_dispatch_start", 32'(dispatch_start), 32'd1);
        drain();
        check_val("single_kc", 32'(kernels_completed), 32'd1);

        // Zero-thread launch retires as aborted without touching dispatch.
        launch(0, 7);
        drain();
        check_val("zero_kc", 32'(kernels_completed), 32'd1);

        // Fill the queue while one kernel is held in RUN.
        done_delay = 1000;
        launch(20, 1);
        wait_run_age(1);
        for (int i = 2; i <= 5; i++) launch(5, i);
        check_val("fill_ready_low", 32'(launch_ready), 32'd0);
        check_val("fill_count", 32'(queue_count), 32'd4);
        done_delay = 3;
        launch(5, 6);
        drain();

        // Abort three cycles into RUN; the next queued kernel runs normally.
        done_delay = 1000;
        launch(9, 10);
        launch(4, 11);
        wait_run_age(3);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        check_val("abort_dispatch_reset", 32'(dispatch_reset), 32'd1);
        check_val("abort_start_low", 32'(dispatch_start), 32'd0);
        done_delay = 2;
        drain();

        // Tie: abort and done on the same edge counts as a good completion.
        kc_before  = m_kc;
        done_delay = 3;
        launch(6, 12);
        wait_run_age(3);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        check_val("tie_aborted", 32'(complete_aborted), 32'd0);
        drain();
        check_val("tie_kc", 32'(kernels_completed), 32'((kc_before + 1) % 256));

        // Random traffic including aborts outside RUN, stray done, and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            rs = ($urandom_range(0, 299) == 0);
            lv = ($urandom_range(0, 9) < 4);
            tc = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            id = int'($urandom_range(0, 15));
            ab = ($urandom_range(0, 9) == 0);
            dx = ($urandom_range(0, 19) == 0);
            if (m_phase != K_RUN) done_delay = int'($urandom_range(0, 6));
            cycle(rs, lv, tc, id, ab, dx);
        end
        drain();

        // Wrap: 256 good kernels from a fresh reset bring the counter back to zero.
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        done_delay = 1;
        for (int i = 0; i < 256; i++) launch(int'($urandom_range(1, 255)), i % 16);
        drain();
        check_val("wrap_kc", 32'(kernels_completed), 32'd0);

        // Reset mid-RUN discards running and queued kernels with no retire pulse.
        done_delay = 1000;
        launch(30, 1);
        launch(31, 2);
        launch(32, 3);
        wait_run_age(2);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check_val("rst_run_qcount", 32'(queue_count), 32'd0);
        check_val("rst_run_cv", 32'(complete_valid), 32'd0);
        idle(6);
        check_val("rst_run_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kernel_scheduler.md
KERNEL_SCHEDULER -- requirements
Module: kernel_scheduler

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, pending-launch queue entries (power of two, >=2).
REQ-002 SHALL have parameter ID_BITS, default 4, kernel tag width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 launch_valid  input  1  launch request present.
REQ-006 launch_ready  output  1  queue can accept a launch; equals not-full, registered, independent of the current-cycle pop.
REQ-007 launch_thread_count  input  8  total threads for the kernel.
REQ-008 launch_kernel_id  input  ID_BITS  caller tag, returned on completion.
REQ-009 abort  input  1  one-cycle request to cancel the running kernel.
REQ-010 dispatch_reset  output  1  reset to the block-dispatch unit.
REQ-011 dispatch_start  output  1  start level to the block-dispatch unit.
REQ-012 dispatch_thread_count  output  8  thread_count to the block-dispatch unit.
REQ-013 dispatch_done  input  1  kernel-done level from the block-dispatch unit.
REQ-014 complete_valid  output  1  one-cycle retire pulse.
REQ-015 complete_kernel_id  output  ID_BITS  tag of the retired kernel, valid with complete_valid.
REQ-016 complete_aborted  output  1  retired kernel was aborted or skipped, valid with complete_valid.
REQ-017 queue_count  output  $clog2(QUEUE_DEPTH)+1  occupied queue entries.
REQ-018 busy  output  1  high in any state other than IDLE, or when queue_count is nonzero.
REQ-019 kernels_completed  output  8  count of retires with complete_aborted=0; wraps 255->0.

Function
REQ-020 A launch SHALL be accepted on every edge where launch_valid and launch_ready are both high; push and pop on the same edge SHALL leave queue_count unchanged.
REQ-021 The FSM SHALL have states IDLE, CLEAR, RUN, RETIRE.
REQ-022 IDLE with queue nonempty SHALL pop the head into registered dispatch_thread_count and kernel tag, then go to CLEAR; an empty queue SHALL stay in IDLE.
REQ-023 If the popped thread_count is 0, the FSM SHALL go directly to RETIRE with complete_aborted=1, never raising dispatch_reset or dispatch_start.
REQ-024 CLEAR SHALL assert dispatch_reset for exactly one cycle with dispatch_start=0, then go to RUN.
REQ-025 RUN SHALL hold dispatch_start=1 and dispatch_thread_count stable until dispatch_done is sampled high, then go to RETIRE.
REQ-026 RETIRE SHALL drive dispatch_start=0, pulse complete_valid for one cycle, increment kernels_completed when not aborted, and return to IDLE.
REQ-027 Latency: for a launch accepted on edge E0 into an empty queue with the FSM in IDLE, dispatch_reset SHALL be high after E1 and dispatch_start high after E2.
REQ-028 abort in RUN SHALL, on that edge, drop dispatch_start, assert dispatch_reset for one cycle, and go to RETIRE with complete_aborted=1.
REQ-029 abort outside RUN SHALL be ignored.
REQ-030 abort and dispatch_done sampled high on the same edge SHALL retire with complete_aborted=0; done wins.
REQ-031 A dispatch_done high while not in RUN SHALL be ignored.
REQ-032 Back-to-back kernels SHALL always pass through CLEAR, so each kernel sees a fresh dispatch reset.

Reset
REQ-033 On reset the FSM SHALL enter IDLE and the queue SHALL be emptied.
REQ-034 Reset values: queue_count=0, launch_ready=1, dispatch_reset=1, dispatch_start=0, dispatch_thread_count=0, complete_valid=0, complete_kernel_id=0, complete_aborted=0, kernels_completed=0, busy=0.
REQ-035 dispatch_reset SHALL deassert on the first edge after reset releases.
REQ-036 Reset mid-RUN SHALL discard the running kernel and all queued kernels with no complete_valid pulse.

Structure
REQ-037 Package gpu_sched_pkg SHALL hold the FSM state enum and the ID_BITS and QUEUE_DEPTH defaults.
REQ-038 The queue SHALL be a sub-module launch_fifo (synchronous FIFO, registered full/empty/count); the FSM stays in kernel_scheduler.

Verification
REQ-039 Single launch: thread_count=10, id=3; model asserts done 5 cycles after start -> reset pulse at E1, start at E2, complete_valid with id=3, aborted=0, kernels_completed=1.
REQ-040 Fill: 5 launches back-to-back with QUEUE_DEPTH=4 and FSM held in RUN -> launch_ready low after the 4th acceptance, queue_count=4, the 5th launch is stalled and accepted after the next pop.
REQ-041 Zero threads: launch thread_count=0, id=7 -> no dispatch_reset/start, complete_valid with id=7, aborted=1, kernels_completed unchanged.
REQ-042 Abort: abort 3 cycles into RUN -> start low and a one-cycle dispatch_reset on that edge, completion with aborted=1, the next queued kernel then proceeds normally.
REQ-043 Tie: abort and dispatch_done high on the same edge -> aborted=0, counter increments.
REQ-044 Wrap: 256 good kernels -> kernels_completed returns to 0; reset mid-RUN -> no complete_valid, queue_count=0.
